// File: rtl/uart_mem_dump.sv
// Streams a block of 32-bit words from a synchronous-read memory out of an
// 8N1 UART transmitter, little-endian within each word.
module uart_mem_dump #(
  parameter int CLKS_PER_BIT = 87,
  parameter int ADDR_W       = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W:0]   WL_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_START, S_DATA, S_STOP
  } state_e;

  state_e            state_q, state_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W:0]   words_left_q, words_left_d;
  logic [31:0]       shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic              bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  // NOTE: every signal gets its default before the case so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    tx_d         = tx_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    mem_addr_d   = mem_addr_q;
    words_left_d = words_left_q;
    shift_d      = shift_q;
    cnt_d        = '0;
    bit_idx_d    = bit_idx_q;
    byte_idx_d   = byte_idx_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d      = S_FETCH;
          busy_d       = 1'b1;
          mem_addr_d   = base_addr;
          words_left_d = word_count;
        end
      end
      S_FETCH: begin
        // Only a zero word_count reaches FETCH with nothing left to send.
        if (words_left_q == '0) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d      = S_WAIT;
          words_left_d = words_left_q - WL_ONE;
        end
      end
      S_WAIT: begin
        state_d    = S_START;
        shift_d    = mem_rdata;
        tx_d       = 1'b0;
        bit_idx_d  = '0;
      end
      S_START: begin
        cnt_d = bit_end ? '0 : cnt_q + CNT_ONE;
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        cnt_d = bit_end ? '0 : cnt_q + CNT_ONE;
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'd7) begin
            state_d   = S_STOP;
            tx_d      = 1'b1;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end
      end
      S_STOP: begin
        cnt_d = bit_end ? '0 : cnt_q + CNT_ONE;
        if (bit_end) begin
          if (byte_idx_q != 2'd3) begin
            state_d    = S_START;
            tx_d       = 1'b0;
            byte_idx_d = byte_idx_q + 2'd1;
          end else begin
            byte_idx_d = '0;
            if (words_left_q != '0) begin
              state_d    = S_FETCH;
              mem_addr_d = mem_addr_q + ADDR_ONE;
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides whatever the dump was about to do, including a done pulse.
    if (abort && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      tx_d       = 1'b1;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      cnt_d      = '0;
      bit_idx_d  = '0;
      byte_idx_d = '0;
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mem_addr_q   <= '0;
      words_left_q <= '0;
      shift_q      <= '0;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      byte_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      mem_addr_q   <= mem_addr_d;
      words_left_q <= words_left_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      byte_idx_q   <= byte_idx_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_uart_mem_dump.sv
// Directed bench for uart_mem_dump at 4 clocks per bit with a registered-read
// memory model; each scenario task checks tx/busy/done/mem_addr cycle-exactly.
module tb_uart_mem_dump;
  localparam int C  = 4;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          reset, start, abort;
  logic [AW-1:0] base_addr;
  logic [AW:0]   word_count;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;
  logic          tx, busy, done;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  uart_mem_dump #(.CLKS_PER_BIT(C), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .base_addr(base_addr), .word_count(word_count), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    case (a)
      14'h0010: return 32'h44332211;
      14'h3FFF: return 32'hDDCCBBAA;
      14'h0000: return 32'h87654321;
      14'h0020: return 32'hF00DCAFE;
      default:  return 32'hDEADBEEF;
    endcase
  endfunction

  always @(posedge clk) mem_rdata <= mem_word(mem_addr);
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Issue a one-cycle start; returns just after the accepting edge N.
  task automatic start_dump(input logic [AW-1:0] b, input logic [AW:0] n);
    start = 1'b1; base_addr = b; word_count = n;
    step();
    start = 1'b0; base_addr = 14'h1555; word_count = 15'd5;
  endtask

  // Entered just after the edge that begins a start bit; exits just after the
  // edge that ends the stop bit. poke>=0 re-pulses start with another base.
  task automatic check_frame(input logic [7:0] b, input string tag, input int poke);
    logic exp, got;
    for (int k = 0; k < 10; k++) begin
      exp = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      got = exp;
      for (int c = 0; c < C; c++) begin
        if (tx !== exp) got = tx;
        if (k * C + c == poke) begin
          start = 1'b1; base_addr = 14'h0020; word_count = 15'd1;
        end
        step();
        start = 1'b0;
      end
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL %s byte %h bit%0d: tx=%b expected %b", tag, b, k, got, exp);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0; word_count = '0;
    steps(3);
    total++; if (tx !== 1'b1)    begin bad++; $display("FAIL reset.tx: got %b want 1", tx); end
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset.busy: got %b want 0", busy); end
    total++; if (done !== 1'b0)  begin bad++; $display("FAIL reset.done: got %b want 0", done); end
    total++; if (mem_addr !== '0) begin bad++; $display("FAIL reset.mem_addr: got %h want 0", mem_addr); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_word();
    int d0 = done_cnt;
    start_dump(14'h0010, 15'd1);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single.busy_N: got %b want 1", busy); end
    total++; if (mem_addr !== 14'h0010) begin bad++; $display("FAIL single.addr: got %h want 0010", mem_addr); end
    step();
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL single.tx_N1: got %b want 1", tx); end
    step();
    check_frame(8'h11, "single", -1);
    check_frame(8'h22, "single", -1);
    check_frame(8'h33, "single", -1);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL single.done_early: got %b want 0", done); end
    check_frame(8'h44, "single", -1);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL single.done_N162: got %b want 1", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single.busy_N162: got %b want 0", busy); end
    total++; if (tx !== 1'b1)   begin bad++; $display("FAIL single.tx_end: got %b want 1", tx); end
    step();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL single.done_len: got %b want 0", done); end
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL single.done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_two_words_wrap();
    int d0 = done_cnt;
    start_dump(14'h3FFF, 15'd2);
    total++; if (mem_addr !== 14'h3FFF) begin bad++; $display("FAIL wrap.addr0: got %h want 3fff", mem_addr); end
    steps(2);
    check_frame(8'hAA, "wrap", -1);
    check_frame(8'hBB, "wrap", -1);
    check_frame(8'hCC, "wrap", -1);
    check_frame(8'hDD, "wrap", -1);
    total++; if (mem_addr !== 14'h0000) begin bad++; $display("FAIL wrap.addr1: got %h want 0000", mem_addr); end
    total++; if (tx !== 1'b1)   begin bad++; $display("FAIL wrap.gap0: got %b want 1", tx); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL wrap.busy_gap: got %b want 1", busy); end
    step();
    total++; if (tx !== 1'b1)   begin bad++; $display("FAIL wrap.gap1: got %b want 1", tx); end
    step();
    check_frame(8'h21, "wrap", -1);
    check_frame(8'h43, "wrap", -1);
    check_frame(8'h65, "wrap", -1);
    check_frame(8'h87, "wrap", -1);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL wrap.done: got %b want 1", done); end
    total++; if (mem_addr !== 14'h0000) begin bad++; $display("FAIL wrap.addr_end: got %h want 0000", mem_addr); end
    steps(3);
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL wrap.done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_zero_count();
    int d0 = done_cnt;
    start_dump(14'h0020, 15'd0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL zero.busy_N: got %b want 1", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL zero.done_N: got %b want 0", done); end
    total++; if (mem_addr !== 14'h0020) begin bad++; $display("FAIL zero.addr: got %h want 0020", mem_addr); end
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero.busy_N1: got %b want 0", busy); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL zero.done_N1: got %b want 1", done); end
    begin
      logic seen_low = 1'b0;
      for (int i = 0; i < 12; i++) begin
        if (tx !== 1'b1) seen_low = 1'b1;
        step();
      end
      total++; if (seen_low !== 1'b0) begin bad++; $display("FAIL zero.tx_idle: tx left 1 (seen_low=%b)", seen_low); end
    end
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL zero.done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_abort();
    int d0 = done_cnt;
    start_dump(14'h0010, 15'd3);
    steps(2);
    check_frame(8'h11, "abort", -1);
    steps(21);
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL abort.bit4: got %b want 0", tx); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    total++; if (tx !== 1'b1)   begin bad++; $display("FAIL abort.tx: got %b want 1", tx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort.busy: got %b want 0", busy); end
    steps(8);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL abort.tx_after: got %b want 1", tx); end
    total++; if (done_cnt - d0 !== 0) begin bad++; $display("FAIL abort.no_done: got %0d want 0", done_cnt - d0); end
    start = 1'b1; abort = 1'b1; base_addr = 14'h0020; word_count = 15'd1;
    step();
    start = 1'b0; abort = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort.start_with_abort: busy=%b want 0", busy); end
    step();
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL abort.start_with_abort_tx: got %b want 1", tx); end
    start_dump(14'h0020, 15'd1);
    steps(2);
    check_frame(8'hFE, "post_abort", -1);
    check_frame(8'hCA, "post_abort", -1);
    check_frame(8'h0D, "post_abort", -1);
    check_frame(8'hF0, "post_abort", -1);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL post_abort.done: got %b want 1", done); end
    step();
  endtask

  task automatic test_ignored_start_and_reset();
    start_dump(14'h0010, 15'd1);
    steps(2);
    check_frame(8'h11, "ignored", 17);
    check_frame(8'h22, "ignored", -1);
    check_frame(8'h33, "ignored", -1);
    check_frame(8'h44, "ignored", -1);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL ignored.done: got %b want 1", done); end
    total++; if (mem_addr !== 14'h0010) begin bad++; $display("FAIL ignored.addr: got %h want 0010", mem_addr); end
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignored.busy_after: got %b want 0", busy); end
    steps(3);
    start_dump(14'h0010, 15'd1);
    steps(2);
    check_frame(8'h11, "midreset", -1);
    steps(5);
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL midreset.pre: got %b want 0", tx); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (tx !== 1'b1)   begin bad++; $display("FAIL midreset.tx: got %b want 1", tx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset.busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midreset.done: got %b want 0", done); end
    total++; if (mem_addr !== '0) begin bad++; $display("FAIL midreset.addr: got %h want 0", mem_addr); end
    begin
      logic seen_low = 1'b0;
      for (int i = 0; i < 50; i++) begin
        if (tx !== 1'b1) seen_low = 1'b1;
        step();
      end
      total++; if (seen_low !== 1'b0) begin bad++; $display("FAIL midreset.residual: tx left 1 (seen_low=%b)", seen_low); end
    end
    start_dump(14'h0010, 15'd1);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midreset.restart_busy: got %b want 1", busy); end
    steps(2);
    check_frame(8'h11, "restart", -1);
    check_frame(8'h22, "restart", -1);
    check_frame(8'h33, "restart", -1);
    check_frame(8'h44, "restart", -1);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL restart.done: got %b want 1", done); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_two_words_wrap();
    test_zero_count();
    test_abort();
    test_ignored_start_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
